rls_update_seq: RTL
===================

Name: rls_update_seq

Overview:
- Sequencer for the RLS state-update datapath: row-by-col a'·x0, then b − a'x0, then scalar×vector k(b − a'x0), then vector add x0 + k(...).
- Accepts one sample per valid/ready handshake and generates the stage restart/reset levels and pipeline-register load enables.
- Presents the result through a valid/ready handshake.
- Sits between the sample source (a, b, x0, k) and the update datapath; holds no data itself.

Parameters:
- SIZE, 16, vector length.
- COMBSIZE, 4, elements combined per cycle in row-by-col and vector-add stages.
- STAGE_WAIT, 1+SIZE/COMBSIZE, cycles spent in each of RBC_RUN, SV_RUN, VA_RUN; must be ≥1.
- ITER_W, 16, width of the iteration counter.

Ports:
- clk, in, 1, clock; all state changes on posedge.
- reset, in, 1, asynchronous, active-low reset.
- in_valid, in, 1, new sample (a, b, x0, k) is stable on datapath inputs.
- in_ready, out, 1, sequencer can accept a sample.
- sample_load, out, 1, combinational in_valid & in_ready; datapath captures its inputs.
- abort, in, 1, synchronous cancel of the current update.
- rbc_restart, out, 1, restart level for the row-by-col unit.
- sv_reset, out, 1, reset level for the scalar×vector unit.
- va_reset, out, 1, reset level for the vector-add unit.
- atx_load, out, 1, enable for the a'x0 register.
- batx_load, out, 1, enable for the b − a'x0 register.
- kbatx_load, out, 1, enable for the k(b − a'x0) register.
- out_valid, out, 1, result x valid.
- out_ready, in, 1, consumer accepts the result.
- busy, out, 1, high in any state except IDLE.
- iter_count, out, ITER_W, count of completed result handshakes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, rbc_restart=1, sv_reset=1, va_reset=1, all loads 0, out_valid=0, busy=0, stage counter 0, iter_count 0.
- All outputs except sample_load are registered (Moore decode of next state).
- States: IDLE, RBC_INIT, RBC_RUN, SV_RUN, VA_RUN, DONE.
- IDLE: in_ready=1; all stage resets held at 1; loads 0. On in_valid → RBC_INIT.
- RBC_INIT (1 cycle): rbc_restart=1, in_ready=0, busy=1 → RBC_RUN, counter cleared.
- RBC_RUN (STAGE_WAIT cycles): rbc_restart=0, atx_load=1, sv_reset=1, va_reset=1. When counter reaches STAGE_WAIT-1 → SV_RUN, counter cleared.
- SV_RUN (STAGE_WAIT cycles): atx_load=0, sv_reset=0, batx_load=1, va_reset=1 → VA_RUN.
- VA_RUN (STAGE_WAIT cycles): batx_load=0, va_reset=0, kbatx_load=1 → DONE.
- DONE: kbatx_load=0, va_reset stays 0 so x is held, out_valid=1. Stays until out_ready. Then → IDLE, out_valid=0, iter_count+1.
- Latency: accept edge E0 → out_valid at E0+1+3·STAGE_WAIT edges; 16 for defaults.
- Stage counter width: clog2(STAGE_WAIT+1).
- iter_count wraps from 2^ITER_W−1 to 0.
- Abort:
  - In RBC_INIT..VA_RUN: next state IDLE, loads 0, resets 1, no out_valid, iter_count unchanged.
  - In DONE: ignored (the result is already valid).
  - In IDLE: abort has priority over in_valid; no accept, sample_load=0 that cycle.
- in_valid while not in IDLE is ignored; no queuing.
- out_ready outside DONE is ignored.
- Reset asserted mid-operation: immediate return to reset values; partial result discarded.

Optional Feature:
- Macro RLS_SEQ_BACKTOBACK_EN.
- Defined: in DONE, in_ready = out_ready (registered-state decode plus combinational out_ready term). If out_valid & out_ready & in_valid in the same cycle: result retires, iter_count+1, sample_load=1, next state RBC_INIT directly. Sustained throughput is one result per 1+3·STAGE_WAIT+1 cycles.
- Undefined: in_ready=0 in DONE; one IDLE cycle between results is mandatory.

Decomposition:
- Package rls_pkg: state enum encoding (3 bits), default SIZE/COMBSIZE, STAGE_WAIT derivation function, clog2 helper.
- One natural sub-module: rls_stage_timer. Loadable down-counter with a terminal-count flag, reused for all three timed states.
- FSM and output decode stay in rls_update_seq.

Test Plan:
- Reset release, in_valid=1 at cycle 3 → sample_load high at cycle 3. rbc_restart 1 for exactly one cycle after accept, then 0. atx_load high for 5 cycles, batx_load 5, kbatx_load 5. out_valid at accept+16. iter_count 0→1 after out_ready.
- out_ready held low for 10 cycles in DONE → out_valid stays 1, x held (va_reset=0), in_ready=0, no reload. out_ready=1 → IDLE next cycle.
- abort at accept+7 (SV_RUN) → IDLE next cycle, all resets 1. out_valid never asserted, iter_count unchanged. New in_valid accepted normally afterwards.
- Asynchronous reset low mid-VA_RUN (no clock edge) → outputs at reset values immediately. Release, then a normal run still takes 16 cycles.
- iter_count with ITER_W=2: 4 complete updates → counts 1, 2, 3, 0.
- RLS_SEQ_BACKTOBACK_EN: in_valid and out_ready held high → consecutive out_valid pulses 17 cycles apart. Without the macro → 18 cycles apart.

Source files
------------

// File: rtl/rls_pkg.sv
// Shared types and helpers for the RLS update sequencer: state encoding,
// registered control-output bundle and its Moore decode.
package rls_pkg;

  localparam int SIZE_DEF     = 16;
  localparam int COMBSIZE_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RBC_INIT = 3'd1,
    S_RBC_RUN  = 3'd2,
    S_SV_RUN   = 3'd3,
    S_VA_RUN   = 3'd4,
    S_DONE     = 3'd5
  } rls_state_e;

  typedef struct packed {
    logic in_ready;
    logic rbc_restart;
    logic sv_reset;
    logic va_reset;
    logic atx_load;
    logic batx_load;
    logic kbatx_load;
    logic out_valid;
    logic busy;
  } rls_ctl_t;

  function automatic int stage_wait(input int size, input int combsize);
    return 1 + size / combsize;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Control levels as seen while sitting in state s; unreachable codes look idle.
  function automatic rls_ctl_t ctl_decode(input rls_state_e s);
    rls_ctl_t c;
    c      = '0;
    c.busy = 1'b1;
    case (s)
      S_RBC_INIT: begin c.rbc_restart = 1'b1; c.sv_reset = 1'b1; c.va_reset = 1'b1; end
      S_RBC_RUN:  begin c.atx_load = 1'b1; c.sv_reset = 1'b1; c.va_reset = 1'b1; end
      S_SV_RUN:   begin c.batx_load = 1'b1; c.va_reset = 1'b1; end
      S_VA_RUN:   c.kbatx_load = 1'b1;
      S_DONE:     c.out_valid = 1'b1;
      default: begin
        c.in_ready    = 1'b1;
        c.rbc_restart = 1'b1;
        c.sv_reset    = 1'b1;
        c.va_reset    = 1'b1;
        c.busy        = 1'b0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rls_update_seq_timer.sv
// Loadable down-counter with terminal-count flag, shared by the three timed
// stages of the RLS update sequencer.
module rls_stage_timer #(
  parameter int CNT_W    = 3,
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (load_i)                cnt_d = CNT_W'(LOAD_VAL);
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/rls_update_seq.sv
// Sequencer for the RLS state-update datapath (a'x0 -> b-a'x0 -> k(..) -> x0+k(..)).
// Define RLS_SEQ_BACKTOBACK_EN to let a new sample be accepted in the result-retire cycle.
module rls_update_seq
  import rls_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int COMBSIZE   = COMBSIZE_DEF,
  parameter int STAGE_WAIT = stage_wait(SIZE, COMBSIZE),
  parameter int ITER_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              sample_load_o,
  input  logic              abort_i,
  output logic              rbc_restart_o,
  output logic              sv_reset_o,
  output logic              va_reset_o,
  output logic              atx_load_o,
  output logic              batx_load_o,
  output logic              kbatx_load_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic [ITER_W-1:0] iter_count_o
);

  localparam int CNT_W = clog2(STAGE_WAIT + 1);

  rls_state_e        state_q, state_d;
  rls_ctl_t          ctl_q;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              tmr_clr, tmr_load, tmr_dec, tmr_tc;
  logic              in_flight, accept;

  assign in_flight = state_q inside {S_RBC_INIT, S_RBC_RUN, S_SV_RUN, S_VA_RUN};

`ifdef RLS_SEQ_BACKTOBACK_EN
  assign in_ready_o = ctl_q.in_ready | (ctl_q.out_valid & out_ready_i);
`else
  assign in_ready_o = ctl_q.in_ready;
`endif

  // Abort only blocks an accept from IDLE; in DONE it is ignored.
  assign accept        = in_valid_i & in_ready_o & ~(abort_i & (state_q == S_IDLE));
  assign sample_load_o = accept;

  rls_stage_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (STAGE_WAIT - 1)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (accept) state_d = S_RBC_INIT;
      end
      S_RBC_INIT: begin
        tmr_load = 1'b1;
        state_d  = S_RBC_RUN;
      end
      S_RBC_RUN, S_SV_RUN, S_VA_RUN: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          state_d  = (state_q == S_RBC_RUN) ? S_SV_RUN :
                     (state_q == S_SV_RUN)  ? S_VA_RUN : S_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE: begin
        tmr_clr = 1'b1;
        if (out_ready_i) begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = accept ? S_RBC_INIT : S_IDLE;
        end
      end
      default: begin
        tmr_clr = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    if (abort_i && in_flight) begin
      state_d  = S_IDLE;
      tmr_clr  = 1'b1;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctl_q   <= ctl_decode(S_IDLE);
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_decode(state_d);
      iter_q  <= iter_d;
    end

  assign rbc_restart_o = ctl_q.rbc_restart;
  assign sv_reset_o    = ctl_q.sv_reset;
  assign va_reset_o    = ctl_q.va_reset;
  assign atx_load_o    = ctl_q.atx_load;
  assign batx_load_o   = ctl_q.batx_load;
  assign kbatx_load_o  = ctl_q.kbatx_load;
  assign out_valid_o   = ctl_q.out_valid;
  assign busy_o        = ctl_q.busy;
  assign iter_count_o  = iter_q;

endmodule
